uart_rgb_pwm_ctrl: RTL and testbench
====================================

Name: uart_rgb_pwm_ctrl

Overview:
- UART-command-driven RGB controller; successor to the single-byte, on/off LED command decoder.
- Sits between a simpleuart-style data register interface and the SB_RGBA_DRV PWM inputs.
- Adds per-channel PWM duty of parametrised width, multi-byte hex commands, a blink mode, and ACK/NAK replies.

Parameters:
- PWM_W, 8, duty/PWM counter width; legal range 1..8.
- BLINK_W, 22, free-running blink counter width; blink phase is counter MSB.
- ACK_CHAR, 8'h21 ("!"), reply byte for an accepted command.
- NAK_CHAR, 8'h3F ("?"), reply byte for a rejected command.

Ports:
- clk  in  1  system clock (one clock domain).
- reset  in  1  synchronous, active-high reset.
- reg_dat_re  out  1  read strobe; a byte is consumed in any cycle with reg_dat_re=1 and reg_dat_do!=32'hFFFFFFFF.
- reg_dat_do  in  32  UART receive data; 32'hFFFFFFFF means no byte available; byte is in [7:0].
- reg_dat_we  out  1  write strobe; held until accepted.
- reg_dat_di  out  32  transmit data, {24'b0, byte}.
- reg_dat_wait  in  1  write is accepted in a cycle with reg_dat_we=1 and reg_dat_wait=0.
- pwm_red  out  1  PWM drive for the red channel.
- pwm_green  out  1  PWM drive for the green channel.
- pwm_blue  out  1  PWM drive for the blue channel.
- blink_en  out  1  blink mode status.

Behaviour:
- Reset (synchronous, high), applied to all state:
  - state=IDLE; duty_r/g/b = all-ones (white); blink_en=0.
  - PWM counter=0; blink counter=0.
  - reg_dat_we=0; reg_dat_di=0.
- Reset mid-reply drops the pending byte with no retry.
- FSM states: IDLE, HEX_HI, HEX_LO, REPLY.
- reg_dat_re is a combinational decode: 1 in IDLE, HEX_HI and HEX_LO; 0 in REPLY.
- The FSM acts only in cycles where a byte is consumed. Empty cycles (do=FFFFFFFF) leave all state unchanged; there is no timeout.
- IDLE, on byte b:
  - "0".."5": load preset, reply ACK. Presets as (R,G,B), 1 = all-ones duty, 0 = zero duty:
    - "0"=(0,0,0); "1"=(1,0,0); "2"=(1,1,0).
    - "3"=(0,1,0); "4"=(1,1,1); "5"=(0,0,1).
  - "R", "G" or "B": latch the channel select, go to HEX_HI; no reply yet.
  - "K": toggle blink_en, reply ACK.
  - Any other byte, including "6".."9" and lowercase "r"/"g"/"b": reply NAK.
- HEX_HI / HEX_LO:
  - Accept 0-9, A-F, a-f. The first digit is stored as the high nibble.
  - On the second valid digit, the 8-bit value v is formed and the selected duty is written with v[7:8-PWM_W]. Then reply ACK.
  - A non-hex byte in either state aborts, leaves duty unchanged, and replies NAK.
- REPLY:
  - Entry cycle: reg_dat_we=1 and reg_dat_di = ACK or NAK, both registered.
  - Hold until reg_dat_wait=0. The accept cycle clears we on the next edge, and the FSM returns to IDLE.
  - Latency: byte consumed at cycle N -> we=1 at N+1; back to IDLE at earliest N+2.
- Duty/preset update timing: takes effect on the edge after the consuming cycle. The PWM counter is not restarted.
- PWM:
  - PWM_W-bit free-running counter that wraps from all-ones to 0.
  - Channel raw = (duty > cnt), so duty 0 = always off and all-ones = high for 2^PW-1 of every 2^PW cycles.
  - Outputs are registered, one cycle after the compare.
- Blink: BLINK_W counter free-running. Output = raw & ~(blink_en & blink_cnt[BLINK_W-1]).
- Bytes arriving during REPLY stay in the UART FIFO (re=0) and are processed after return to IDLE.

Test Plan:
- Reset with no RX (do=FFFFFFFF), PWM_W=8 -> pwm_* high 255 of every 256 cycles; blink_en=0; we never asserts.
- Feed "1" with wait=0 -> re drops; we=1 with di=0x21 for exactly 1 cycle; afterwards pwm_red toggles at 255/256, green and blue constant 0.
- Feed "G","8","0" (mixed with empty cycles) -> only the third byte produces a reply (0x21); pwm_green high exactly 128 of every 256 cycles; red/blue unchanged.
- PWM_W=4, "B","f","F" -> duty_b=4'hF, high 15 of 16; then "R","3","Z" -> NAK 0x3F and duty_r unchanged.
- Feed "K" with BLINK_W=4 -> blink_en=1, outputs forced 0 whenever blink_cnt[3]=1; a second "K" -> blink_en=0.
- Feed "x" with wait held high 5 cycles -> di=0x3F and we stays 1 for 6 cycles, dropping after the accept; next RX byte is not consumed before return to IDLE. Assert reset mid-"R","4" sequence -> state IDLE, duties all-ones.

Source files
------------

// File: rtl/uart_rgb_pwm_ctrl.sv
// rtl/uart_rgb_pwm_ctrl.sv - UART command decoder driving RGB PWM duty, blink mode and ACK/NAK replies
module uart_rgb_pwm_ctrl #(
  parameter int         PWM_W    = 8,
  parameter int         BLINK_W  = 22,
  parameter logic [7:0] ACK_CHAR = 8'h21,
  parameter logic [7:0] NAK_CHAR = 8'h3F
) (
  input  logic        clk,
  input  logic        reset,
  output logic        reg_dat_re,
  input  logic [31:0] reg_dat_do,
  output logic        reg_dat_we,
  output logic [31:0] reg_dat_di,
  input  logic        reg_dat_wait,
  output logic        pwm_red,
  output logic        pwm_green,
  output logic        pwm_blue,
  output logic        blink_en
);

  typedef enum logic [1:0] {IDLE, HEX_HI, HEX_LO, REPLY} state_t;

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         hi_q, hi_d;
  logic [PWM_W-1:0]   duty_r_q, duty_r_d;
  logic [PWM_W-1:0]   duty_g_q, duty_g_d;
  logic [PWM_W-1:0]   duty_b_q, duty_b_d;
  logic               blink_en_q, blink_en_d;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               we_q, we_d;
  logic [7:0]         di_q, di_d;
  logic [2:0]         pwm_q, pwm_d;

  logic [7:0]         byte_in;
  logic               consume;
  logic               hex_ok;
  logic [3:0]         hex_nib;
  logic [7:0]         hex_val;
  logic               send_reply;
  logic [7:0]         reply_char;
  logic               blank;

  assign byte_in    = reg_dat_do[7:0];
  assign reg_dat_re = (state_q != REPLY);
  assign consume    = reg_dat_re && (reg_dat_do != 32'hFFFF_FFFF);
  assign hex_val    = {hi_q, hex_nib};
  assign reg_dat_we = we_q;
  assign reg_dat_di = {24'h0, di_q};
  assign pwm_red    = pwm_q[0];
  assign pwm_green  = pwm_q[1];
  assign pwm_blue   = pwm_q[2];
  assign blink_en   = blink_en_q;

  always_comb begin
    hex_ok  = 1'b1;
    hex_nib = 4'h0;
    if (byte_in >= "0" && byte_in <= "9") begin
      hex_nib = byte_in[3:0];
    end else if ((byte_in >= "A" && byte_in <= "F") || (byte_in >= "a" && byte_in <= "f")) begin
      hex_nib = byte_in[3:0] + 4'd9;
    end else begin
      hex_ok = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    hi_d        = hi_q;
    duty_r_d    = duty_r_q;
    duty_g_d    = duty_g_q;
    duty_b_d    = duty_b_q;
    blink_en_d  = blink_en_q;
    we_d        = we_q;
    di_d        = di_q;
    send_reply  = 1'b0;
    reply_char  = NAK_CHAR;
    pwm_cnt_d   = pwm_cnt_q + 1'b1;
    blink_cnt_d = blink_cnt_q + 1'b1;

    if (consume) begin
      case (state_q)
        IDLE: begin
          send_reply = 1'b1;
          reply_char = ACK_CHAR;
          case (byte_in)
            "0": begin duty_r_d = '0; duty_g_d = '0; duty_b_d = '0; end
            "1": begin duty_r_d = '1; duty_g_d = '0; duty_b_d = '0; end
            "2": begin duty_r_d = '1; duty_g_d = '1; duty_b_d = '0; end
            "3": begin duty_r_d = '0; duty_g_d = '1; duty_b_d = '0; end
            "4": begin duty_r_d = '1; duty_g_d = '1; duty_b_d = '1; end
            "5": begin duty_r_d = '0; duty_g_d = '0; duty_b_d = '1; end
            "R": begin sel_d = 2'd0; state_d = HEX_HI; send_reply = 1'b0; end
            "G": begin sel_d = 2'd1; state_d = HEX_HI; send_reply = 1'b0; end
            "B": begin sel_d = 2'd2; state_d = HEX_HI; send_reply = 1'b0; end
            "K": blink_en_d = ~blink_en_q;
            default: reply_char = NAK_CHAR;
          endcase
        end
        HEX_HI: begin
          if (hex_ok) begin
            hi_d    = hex_nib;
            state_d = HEX_LO;
          end else begin
            send_reply = 1'b1;
          end
        end
        HEX_LO: begin
          send_reply = 1'b1;
          if (hex_ok) begin
            reply_char = ACK_CHAR;
            // Narrow PWM keeps the most significant bits of the hex byte.
            case (sel_q)
              2'd0:    duty_r_d = hex_val[7 -: PWM_W];
              2'd1:    duty_g_d = hex_val[7 -: PWM_W];
              default: duty_b_d = hex_val[7 -: PWM_W];
            endcase
          end
        end
        default: ;
      endcase
    end

    if (send_reply) begin
      state_d = REPLY;
      we_d    = 1'b1;
      di_d    = reply_char;
    end

    if (state_q == REPLY && we_q && !reg_dat_wait) begin
      we_d    = 1'b0;
      state_d = IDLE;
    end

    blank    = blink_en_q & blink_cnt_q[BLINK_W-1];
    pwm_d[0] = (duty_r_q > pwm_cnt_q) & ~blank;
    pwm_d[1] = (duty_g_q > pwm_cnt_q) & ~blank;
    pwm_d[2] = (duty_b_q > pwm_cnt_q) & ~blank;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      hi_q        <= 4'h0;
      duty_r_q    <= '1;
      duty_g_q    <= '1;
      duty_b_q    <= '1;
      blink_en_q  <= 1'b0;
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      we_q        <= 1'b0;
      di_q        <= 8'h0;
      pwm_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      hi_q        <= hi_d;
      duty_r_q    <= duty_r_d;
      duty_g_q    <= duty_g_d;
      duty_b_q    <= duty_b_d;
      blink_en_q  <= blink_en_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      we_q        <= we_d;
      di_q        <= di_d;
      pwm_q       <= pwm_d;
    end
  end

endmodule

// File: tb/tb_uart_rgb_pwm_ctrl.sv
// tb/tb_uart_rgb_pwm_ctrl.sv - directed vector bench for uart_rgb_pwm_ctrl at PWM_W=8 and PWM_W=4
module tb_uart_rgb_pwm_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] rx_do;
  logic        tx_wait;

  logic        re8, we8, r8, g8, b8, blink8;
  logic [31:0] di8;
  logic        re4, we4, r4, g4, b4, blink4;
  logic [31:0] di4;

  uart_rgb_pwm_ctrl #(.PWM_W(8), .BLINK_W(4)) dut8 (
    .clk(clk), .reset(reset),
    .reg_dat_re(re8), .reg_dat_do(rx_do),
    .reg_dat_we(we8), .reg_dat_di(di8), .reg_dat_wait(tx_wait),
    .pwm_red(r8), .pwm_green(g8), .pwm_blue(b8), .blink_en(blink8)
  );

  uart_rgb_pwm_ctrl #(.PWM_W(4), .BLINK_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .reg_dat_re(re4), .reg_dat_do(rx_do),
    .reg_dat_we(we4), .reg_dat_di(di4), .reg_dat_wait(tx_wait),
    .pwm_red(r4), .pwm_green(g4), .pwm_blue(b4), .blink_en(blink4)
  );

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    logic [7:0] di;
    int         e0, e1, e2, e3, e4, e5;
  } vec_t;

  vec_t vecs[13];
  int   checks = 0;
  int   errors = 0;
  int   cnt[6];
  logic we_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    @(negedge clk);
    while (re8 !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("re_ready", {31'h0, re8}, 32'h1);
    rx_do = {24'h0, b};
    @(negedge clk);
    rx_do = 32'hFFFF_FFFF;
  endtask

  task automatic wait_reply(input int hold, output logic [7:0] di, output int len, output logic re_during);
    int k;
    k = 0;
    len = 0;
    di = 8'h0;
    re_during = 1'b0;
    while (we8 !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    while (we8 === 1'b1 && len < 100) begin
      len++;
      di = di8[7:0];
      if (re8 !== 1'b0) re_during = 1'b1;
      tx_wait = (len <= hold);
      @(negedge clk);
    end
    tx_wait = 1'b0;
  endtask

  task automatic do_cmd(input string name, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input int n, input logic [7:0] exp_di);
    logic [7:0] bs[3];
    logic [7:0] di;
    int         len;
    logic       rd;
    bs[0] = b0;
    bs[1] = b1;
    bs[2] = b2;
    for (int i = 0; i < n; i++) begin
      send_byte(bs[i]);
      if (i < n - 1) chk({name, "_no_reply"}, {31'h0, we8}, 32'h0);
    end
    wait_reply(0, di, len, rd);
    chk({name, "_di"}, {24'h0, di}, {24'h0, exp_di});
    chk({name, "_we_len"}, len, 1);
    chk({name, "_re_in_reply"}, {31'h0, rd}, 32'h0);
  endtask

  task automatic measure();
    for (int i = 0; i < 6; i++) cnt[i] = 0;
    we_seen = 1'b0;
    repeat (256) begin
      @(negedge clk);
      cnt[0] += int'(r8);
      cnt[1] += int'(g8);
      cnt[2] += int'(b8);
      cnt[3] += int'(r4);
      cnt[4] += int'(g4);
      cnt[5] += int'(b4);
      if (we8 !== 1'b0 || we4 !== 1'b0) we_seen = 1'b1;
    end
  endtask

  task automatic check_counts(input string name, input int e0, input int e1, input int e2,
                              input int e3, input int e4, input int e5);
    measure();
    chk({name, "_red8"}, cnt[0], e0);
    chk({name, "_green8"}, cnt[1], e1);
    chk({name, "_blue8"}, cnt[2], e2);
    chk({name, "_red4"}, cnt[3], e3);
    chk({name, "_green4"}, cnt[4], e4);
    chk({name, "_blue4"}, cnt[5], e5);
  endtask

  initial begin
    logic [7:0] di;
    int         len;
    logic       rd;

    vecs[0]  = '{"1", 8'h0, 8'h0, 1, 8'h21, 255,   0,   0, 240,   0,   0};
    vecs[1]  = '{"G",  "8",  "0", 3, 8'h21, 255, 128,   0, 240, 128,   0};
    vecs[2]  = '{"B",  "f",  "F", 3, 8'h21, 255, 128, 255, 240, 128, 240};
    vecs[3]  = '{"R",  "3",  "Z", 3, 8'h3F, 255, 128, 255, 240, 128, 240};
    vecs[4]  = '{"R",  "3",  "c", 3, 8'h21,  60, 128, 255,  48, 128, 240};
    vecs[5]  = '{"6", 8'h0, 8'h0, 1, 8'h3F,  60, 128, 255,  48, 128, 240};
    vecs[6]  = '{"r", 8'h0, 8'h0, 1, 8'h3F,  60, 128, 255,  48, 128, 240};
    vecs[7]  = '{"5", 8'h0, 8'h0, 1, 8'h21,   0,   0, 255,   0,   0, 240};
    vecs[8]  = '{"2", 8'h0, 8'h0, 1, 8'h21, 255, 255,   0, 240, 240,   0};
    vecs[9]  = '{"B",  "Z", 8'h0, 2, 8'h3F, 255, 255,   0, 240, 240,   0};
    vecs[10] = '{"0", 8'h0, 8'h0, 1, 8'h21,   0,   0,   0,   0,   0,   0};
    vecs[11] = '{"4", 8'h0, 8'h0, 1, 8'h21, 255, 255, 255, 240, 240, 240};
    vecs[12] = '{"3", 8'h0, 8'h0, 1, 8'h21,   0, 255,   0,   0, 240,   0};

    reset   = 1'b1;
    rx_do   = 32'hFFFF_FFFF;
    tx_wait = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_we8", {31'h0, we8}, 32'h0);
    chk("rst_di8", di8, 32'h0);
    chk("rst_re8", {31'h0, re8}, 32'h1);
    chk("rst_blink8", {31'h0, blink8}, 32'h0);
    chk("rst_we4", {31'h0, we4}, 32'h0);
    chk("rst_di4", di4, 32'h0);
    chk("rst_re4", {31'h0, re4}, 32'h1);
    chk("rst_blink4", {31'h0, blink4}, 32'h0);
    reset = 1'b0;

    check_counts("white", 255, 255, 255, 240, 240, 240);
    chk("idle_we", {31'h0, we_seen}, 32'h0);

    for (int v = 0; v < 13; v++) begin
      do_cmd($sformatf("v%0d", v), vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].n, vecs[v].di);
      check_counts($sformatf("v%0d", v), vecs[v].e0, vecs[v].e1, vecs[v].e2,
                   vecs[v].e3, vecs[v].e4, vecs[v].e5);
    end

    // Blink counter and PWM counter start together, so blanking covers half of every 16 cycles.
    do_cmd("pre_blink", "4", 8'h0, 8'h0, 1, 8'h21);
    do_cmd("blink_on", "K", 8'h0, 8'h0, 1, 8'h21);
    chk("blink_en8_on", {31'h0, blink8}, 32'h1);
    chk("blink_en4_on", {31'h0, blink4}, 32'h1);
    check_counts("blink", 128, 128, 128, 128, 128, 128);
    do_cmd("blink_off", "K", 8'h0, 8'h0, 1, 8'h21);
    chk("blink_en8_off", {31'h0, blink8}, 32'h0);
    check_counts("unblink", 255, 255, 255, 240, 240, 240);

    send_byte("x");
    rx_do = {24'h0, "1"};
    wait_reply(5, di, len, rd);
    chk("held_di", {24'h0, di}, 32'h3F);
    chk("held_we_len", len, 6);
    chk("held_re_in_reply", {31'h0, rd}, 32'h0);
    chk("pending_re_idle", {31'h0, re8}, 32'h1);
    @(negedge clk);
    rx_do = 32'hFFFF_FFFF;
    wait_reply(0, di, len, rd);
    chk("pending_di", {24'h0, di}, 32'h21);
    chk("pending_we_len", len, 1);
    check_counts("pending", 255, 0, 0, 240, 0, 0);

    tx_wait = 1'b1;
    send_byte("5");
    chk("midreply_we", {31'h0, we8}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tx_wait = 1'b0;
    chk("midreply_rst_we", {31'h0, we8}, 32'h0);
    chk("midreply_rst_di", di8, 32'h0);
    repeat (3) @(negedge clk);
    chk("midreply_no_retry", {31'h0, we8}, 32'h0);

    do_cmd("pre_hex_rst", "0", 8'h0, 8'h0, 1, 8'h21);
    send_byte("R");
    chk("hex_rst_no_reply", {31'h0, we8}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_counts("hex_rst", 255, 255, 255, 240, 240, 240);
    do_cmd("post_rst_idle", "4", 8'h0, 8'h0, 1, 8'h21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
